bist_signature_analyzer: RTL
============================

# bist_signature_analyzer

Response-side companion to the BIST controller. It consumes the controller's `init`/`running`/`finish` strobes, compacts the circuit-under-test outputs into a multiple-input signature register (MISR) while `running` is high, and at `finish` compares the signature against a golden value. It sits between the CUT outputs and the top-level BIST status pins, and reports a registered `done`/`pass` verdict.

## Interface
- `W`, 16: MISR and CUT-response width.
- `POLY`, 16'h002D: MISR feedback taps. Bit i set means the shifted-out MSB is XORed into bit i.
- `SEED`, 16'h0000: MISR value loaded on `init`.
- `GOLDEN`, 16'h0000: expected final signature; set per CUT at integration.
- `NCLOCK`, 650: controller run length. The expected compaction count is NCLOCK+1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `init`  in  1  one-cycle pulse from the controller; arms a new test.
- `running`  in  1  high on each cycle where `data_in` is compacted.
- `finish`  in  1  one-cycle pulse from the controller; ends the test.
- `data_in`  in  W  CUT response sampled on each running cycle.
- `signature`  out  W  current MISR contents.
- `done`  out  1  verdict valid; held until the next `init` or `reset`.
- `pass`  out  1  meaningful only while `done`=1.
- `busy`  out  1  high in states ARMED and COMPACT.

## Operation
- FSM states: IDLE, ARMED, COMPACT, COMPARE, DONE. `busy` is decoded from the state.
- Reset takes priority over all other inputs. After reset: state IDLE, `signature`=SEED, `done`=0, `pass`=0, `busy`=0, count=0.
- `init` in any state:
  - Loads `signature`<=SEED and clears count, `done` and `pass`.
  - Next state is ARMED.
  - An `init` during COMPACT aborts the run and restarts.
- ARMED or COMPACT with `running`=1:
  - Signature update: `signature` <= ({sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0)) ^ `data_in`.
  - Count increments and saturates at all-ones. The count is $clog2(NCLOCK+2)+1 bits wide.
  - State moves to, or stays in, COMPACT.
- ARMED or COMPACT with `finish`=1: next state is COMPARE. If `running` is also high on that cycle, that cycle's data is compacted first.
- COMPARE lasts exactly one cycle:
  - `pass` <= (`signature`==GOLDEN), combined with the count check when configured.
  - `done` <= 1.
  - Next state is DONE.
- DONE holds the verdict. It leaves only on `init` (to ARMED) or `reset`.
- Ignored inputs:
  - `running` in IDLE, COMPARE or DONE: MISR frozen.
  - `finish` in IDLE, COMPARE or DONE: no effect.
- `init` and `finish` on the same cycle: `init` wins.

## Timing
- `init` at cycle t: `signature`=SEED and `busy`=1 at t+1.
- `running` high at cycle t: the new `signature` is visible at t+1.
- `finish` at cycle t: state is COMPARE at t+1; `done`/`pass` are visible at t+2.
- Full-run latency from `init` to `done`: 2 + (running cycles) + gap cycles + 2.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.

## Configuration
- Macro `BIST_CYCLE_COUNT_CHECK_EN`.
- Defined: `pass` additionally requires count == NCLOCK+1. A short, long or aborted run fails even when the signature aliases to GOLDEN.
- Undefined:
  - `pass` depends on the signature compare only.
  - The count register is still present but does not affect `pass`.
  - Synthesis may prune the count register.

## Test plan
- Reset mid-COMPACT (W=16 defaults): assert `reset` for 1 cycle -> next cycle `signature`=16'h0000, `done`=0, `pass`=0, `busy`=0, state IDLE.
- W=4, POLY=4'h3, SEED=0, GOLDEN=4'h3, NCLOCK=1, macro defined; `init`, then 2 running cycles with `data_in`=4'h1, then `finish` -> `signature`=4'h3 after the 2nd running cycle; `done`=1 and `pass`=1 two cycles after `finish`.
- Same setup with `data_in`=4'h2 on the 2nd running cycle -> `signature`=4'h0; `done`=1 and `pass`=0.
- Same setup with only 1 running cycle: `data_in`=4'h3, then `finish`. The signature is 4'h3, so it aliases to GOLDEN. With the macro defined -> `pass`=0; undefined -> `pass`=1.
- `running`/`finish` pulses in IDLE and after `done` -> `signature` unchanged, `done`/`pass` unchanged.
- `init` asserted during COMPACT, then a clean 2-cycle run -> verdict reflects only the second run (`pass`=1 for the 4'h1,4'h1 data).

Source files
------------

// File: rtl/bist_signature_analyzer.sv
// MISR response compactor with golden-signature verdict for the BIST controller.
// Define BIST_CYCLE_COUNT_CHECK_EN to also require exactly NCLOCK+1 compaction cycles for pass.
module bist_signature_analyzer #(
   parameter int unsigned W      = 16,
   parameter logic [W-1:0] POLY   = 16'h002D,
   parameter logic [W-1:0] SEED   = 16'h0000,
   parameter logic [W-1:0] GOLDEN = 16'h0000,
   parameter int unsigned NCLOCK = 650
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic         running,
   input  logic         finish,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] signature,
   output logic         done,
   output logic         pass,
   output logic         busy
);

   localparam int unsigned CW = $clog2(NCLOCK + 2) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_COMPACT,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_sig;
   logic [CW-1:0] r_count;
   logic          r_done;
   logic          r_pass;

   logic [W-1:0]  w_sig_next;
   logic          w_sig_ok;
   logic          w_cnt_ok;

   // One MISR step: shift left, fold the MSB back through the taps, absorb the response.
   assign w_sig_next = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0) ^ data_in;
   assign w_sig_ok   = (r_sig == GOLDEN);

`ifdef BIST_CYCLE_COUNT_CHECK_EN
   assign w_cnt_ok = (r_count == CW'(NCLOCK + 1));
`else
   assign w_cnt_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sig   <= SEED;
         r_count <= '0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else if (init) begin
         r_state <= S_ARMED;
         r_sig   <= SEED;
         r_count <= '0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            S_ARMED, S_COMPACT: begin
               if (running) begin
                  r_sig   <= w_sig_next;
                  r_state <= S_COMPACT;
                  if (r_count != '1) begin
                     r_count <= r_count + CW'(1);
                  end
               end
               // finish overrides the COMPACT transition; same-cycle data is still absorbed
               if (finish) begin
                  r_state <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               r_pass  <= w_sig_ok && w_cnt_ok;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign signature = r_sig;
   assign done      = r_done;
   assign pass      = r_pass;
   assign busy      = (r_state == S_ARMED) || (r_state == S_COMPACT);

endmodule
